// File: rtl/reg_file_param_pkg.sv
// Shared types and helpers for the parametrised register file.
//   rf_state_e  : sequencer state (sweep in progress / accepting traffic)
//   RF_*        : default geometry and the widest word byte_merge can handle
//   byte_merge  : replaces the strobed byte lanes of an old word with new data
package reg_file_param_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int RF_DATA_WIDTH     = 32;
  localparam int RF_ADDR_WIDTH     = 5;
  // byte_merge works at this width; callers zero-extend in and truncate out.
  localparam int RF_MAX_DATA_WIDTH = 256;
  localparam int RF_MAX_STRB_WIDTH = RF_MAX_DATA_WIDTH / 8;

  function automatic logic [RF_MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [RF_MAX_DATA_WIDTH-1:0] old_word,
    input logic [RF_MAX_DATA_WIDTH-1:0] new_word,
    input logic [RF_MAX_STRB_WIDTH-1:0] strobe
  );
    logic [RF_MAX_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int k = 0; k < RF_MAX_STRB_WIDTH; k++) begin
      if (strobe[k]) merged[8*k +: 8] = new_word[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/reg_file_clear_seq.sv
// Post-reset clear sequencer. After RST it walks CLEAR_ADDR from 0 to
// DEPTH-1, one register per cycle, then settles in RF_READY.
//   CLK        : clock, rising edge
//   RST        : synchronous active-high reset, restarts the sweep at 0
//   BUSY       : high while the sweep is running (exactly DEPTH cycles)
//   CLEAR_ADDR : register to be zeroed on the next edge while BUSY
module reg_file_clear_seq
  import reg_file_param_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  output logic             BUSY,
  output logic [CNT_W-1:0] CLEAR_ADDR
);

  rf_state_e        state;
  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RF_CLEAR;
      count <= '0;
    end else if (state == RF_CLEAR) begin
      // The last register is cleared on the same edge that leaves CLEAR.
      if (count == CNT_W'(DEPTH - 1)) state <= RF_READY;
      count <= count + CNT_W'(1);
    end
  end

  assign BUSY       = (state == RF_CLEAR);
  assign CLEAR_ADDR = count;

endmodule

// File: rtl/register_file_param.sv
// Parametrised 2-read / 1-write register file for the processor datapath.
// Byte-masked writes, registered reads with a valid flag, write-first bypass
// when a read address matches the write address in the same cycle, optional
// hard-wired zero register, and a post-reset sweep that zeroes all entries.
//   CLK, RST          : clock and synchronous active-high reset
//   READ              : read request for both ports
//   ADDR_R1, ADDR_R2  : read addresses
//   WRITE, ADDR_W     : write request and address
//   DATA_W, WSTRB     : write data and per-byte enables
//   DATA_R1, DATA_R2  : registered read data (held when no read)
//   RVALID            : DATA_Rx carry a read accepted on the previous edge
//   BUSY              : clear sweep running; READ and WRITE are ignored
module register_file_param
  import reg_file_param_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    READ,
  input  logic [ADDR_WIDTH-1:0]   ADDR_R1,
  input  logic [ADDR_WIDTH-1:0]   ADDR_R2,
  input  logic                    WRITE,
  input  logic [ADDR_WIDTH-1:0]   ADDR_W,
  input  logic [DATA_WIDTH-1:0]   DATA_W,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic [DATA_WIDTH-1:0]   DATA_R1,
  output logic [DATA_WIDTH-1:0]   DATA_R2,
  output logic                    RVALID,
  output logic                    BUSY
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] clear_addr;
  logic [DATA_WIDTH-1:0] merged_w;
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;
  logic                  wr_zero_reg;
  logic                  wr_en;
  logic                  rd_en;

  reg_file_clear_seq #(
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .CLK        (CLK),
    .RST        (RST),
    .BUSY       (BUSY),
    .CLEAR_ADDR (clear_addr)
  );

  // Word as it will look after this cycle's write; feeds both storage and bypass.
  assign merged_w = DATA_WIDTH'(byte_merge(RF_MAX_DATA_WIDTH'(mem[ADDR_W]),
                                           RF_MAX_DATA_WIDTH'(DATA_W),
                                           RF_MAX_STRB_WIDTH'(WSTRB)));

  assign wr_zero_reg = (ZERO_REG != 0) && (ADDR_W == '0);
  assign wr_en       = WRITE && !BUSY && !RST && (WSTRB != '0) && !wr_zero_reg;
  assign rd_en       = READ && !BUSY;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd1 = mem[ADDR_R1];
    rd2 = mem[ADDR_R2];
    if (WRITE && (ADDR_R1 == ADDR_W)) rd1 = merged_w;
    if (WRITE && (ADDR_R2 == ADDR_W)) rd2 = merged_w;
    // The zero register wins over the bypass.
    if ((ZERO_REG != 0) && (ADDR_R1 == '0)) rd1 = '0;
    if ((ZERO_REG != 0) && (ADDR_R2 == '0)) rd2 = '0;
  end

  // NOTE: the storage array has no reset branch; the post-reset sweep zeroes
  // it one entry per cycle, which keeps it mappable to plain RAM/flops.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (BUSY)       mem[clear_addr] <= '0;
      else if (wr_en) mem[ADDR_W]     <= merged_w;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      DATA_R1 <= '0;
      DATA_R2 <= '0;
      RVALID  <= 1'b0;
    end else begin
      RVALID <= rd_en;
      if (rd_en) begin
        DATA_R1 <= rd1;
        DATA_R2 <= rd2;
      end
    end
  end

endmodule

// File: tb/tb_register_file_param.sv
module tb_register_file_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          read = 1'b0;
  logic [AW-1:0] addr_r1 = '0;
  logic [AW-1:0] addr_r2 = '0;
  logic          write = 1'b0;
  logic [AW-1:0] addr_w = '0;
  logic [DW-1:0] data_w = '0;
  logic [3:0]    wstrb = '0;
  logic [DW-1:0] data_r1;
  logic [DW-1:0] data_r2;
  logic          rvalid;
  logic          busy;

  register_file_param #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .ZERO_REG   (1)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .READ    (read),
    .ADDR_R1 (addr_r1),
    .ADDR_R2 (addr_r2),
    .WRITE   (write),
    .ADDR_W  (addr_w),
    .DATA_W  (data_w),
    .WSTRB   (wstrb),
    .DATA_R1 (data_r1),
    .DATA_R2 (data_r2),
    .RVALID  (rvalid),
    .BUSY    (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: register contents plus expected visible outputs.
  logic [DW-1:0] m_reg [DEPTH];
  int            m_busy_left = 0;
  logic [DW-1:0] m_r1 = '0;
  logic [DW-1:0] m_r2 = '0;
  logic          m_rvalid = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return (a == 0) ? '0 : m_reg[a];
  endfunction

  // One clock: drive inputs, advance the model by the specification's rules,
  // then compare all outputs shortly after the edge.
  task automatic step(input bit s_rst, input bit s_rd, input bit s_wr,
                      input logic [AW-1:0] s_a1, input logic [AW-1:0] s_a2,
                      input logic [AW-1:0] s_aw, input logic [DW-1:0] s_dw,
                      input logic [3:0] s_st);
    @(negedge clk);
    rst = s_rst; read = s_rd; write = s_wr;
    addr_r1 = s_a1; addr_r2 = s_a2; addr_w = s_aw; data_w = s_dw; wstrb = s_st;
    @(posedge clk);
    if (s_rst) begin
      // The sweep completes before any traffic is accepted, so contents are 0.
      m_busy_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_reg[i] = '0;
      m_r1 = '0; m_r2 = '0; m_rvalid = 1'b0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      m_rvalid = 1'b0;
    end else begin
      if (s_wr && s_aw != 0)
        for (int k = 0; k < 4; k++)
          if (s_st[k]) m_reg[s_aw][8*k +: 8] = s_dw[8*k +: 8];
      m_rvalid = s_rd;
      if (s_rd) begin
        m_r1 = model_read(s_a1);
        m_r2 = model_read(s_a2);
      end
    end
    #1;
    check("busy",    DW'(busy),   DW'(m_busy_left > 0));
    check("rvalid",  DW'(rvalid), DW'(m_rvalid));
    check("data_r1", data_r1, m_r1);
    check("data_r2", data_r2, m_r2);
  endtask

  task automatic idle();
    step(0, 0, 0, '0, '0, '0, '0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    step(0, 0, 1, '0, '0, a, d, s);
  endtask

  task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    step(0, 1, 0, a1, a2, '0, '0, '0);
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < DEPTH; i++) begin
      rd(AW'(i), AW'(DEPTH - 1 - i));
      check("sweep_zero", data_r1, '0);
    end
  endtask

  initial begin
    // Initial reset and sweep.
    step(1, 0, 0, '0, '0, '0, '0, '0);
    for (int i = 0; i < DEPTH; i++) idle();

    // Reset sweep over garbage.
    for (int i = 0; i < DEPTH; i++) wr(AW'(i), $urandom(), 4'hF);
    step(1, 0, 0, '0, '0, '0, '0, '0);
    check("busy_after_rst", DW'(busy), DW'(1));
    for (int i = 0; i < DEPTH - 1; i++) idle();
    check("busy_last_cycle", DW'(busy), DW'(1));
    idle();
    check("busy_dropped", DW'(busy), DW'(0));
    read_all_zero();

    // Basic write/read.
    wr(5, 32'hDEADBEEF, 4'hF);
    rd(5, 6);
    check("basic_r1", data_r1, 32'hDEADBEEF);
    check("basic_r2", data_r2, 32'h0);

    // Byte strobe.
    wr(7, 32'h11223344, 4'hF);
    wr(7, 32'hAABBCCDD, 4'b0101);
    rd(7, 7);
    check("strobe_r7", data_r1, 32'h11BB33DD);

    // WSTRB=0 writes nothing.
    wr(7, 32'hFFFFFFFF, 4'h0);
    rd(7, 5);
    check("strobe_none", data_r1, 32'h11BB33DD);

    // Bypass on both ports.
    step(0, 1, 1, 9, 9, 9, 32'h12345678, 4'hF);
    check("bypass_r1", data_r1, 32'h12345678);
    check("bypass_r2", data_r2, 32'h12345678);

    // Partial-strobe bypass merges with the stored word.
    step(0, 1, 1, 9, 7, 9, 32'hAAAAAAAA, 4'b1000);
    check("bypass_part", data_r1, 32'hAA345678);

    // Zero register.
    step(0, 1, 1, 0, 0, 0, 32'hFFFFFFFF, 4'hF);
    check("zero_bypass", data_r1, 32'h0);
    rd(5, 0);
    rd(0, 5);
    check("zero_later", data_r1, 32'h0);
    rd(5, 0);
    idle();
    check("hold_rvalid", DW'(rvalid), DW'(0));
    check("hold_data", data_r1, 32'hDEADBEEF);

    // Mid-sweep reset with writes attempted during BUSY.
    step(1, 0, 0, '0, '0, '0, '0, '0);
    for (int i = 0; i < 10; i++) idle();
    step(1, 0, 0, '0, '0, '0, '0, '0);
    for (int i = 0; i < DEPTH - 1; i++) begin
      step(0, 1, 1, AW'(i), AW'(i), AW'(i), 32'hCAFEF00D, 4'hF);
      check("busy_restart", DW'(busy), DW'(1));
    end
    idle();
    check("busy_restart_end", DW'(busy), DW'(0));
    read_all_zero();

    // RST wins over a simultaneous write.
    wr(3, 32'h55555555, 4'hF);
    step(1, 1, 1, 3, 3, 3, 32'h77777777, 4'hF);
    for (int i = 0; i < DEPTH; i++) idle();
    rd(3, 3);
    check("rst_priority", data_r1, 32'h0);

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      bit            r_rst;
      logic [AW-1:0] a1, a2, aw;
      r_rst = ($urandom_range(0, 199) == 0);
      a1 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom());
      a2 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom());
      aw = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom());
      step(r_rst, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
           a1, a2, aw, $urandom(), 4'($urandom()));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
